// File: rtl/in_xif.sv
// Shared XIF typedefs for the memory interface.
// Request, handshake response and result bundles.
package in_xif;

  localparam int X_ID_WIDTH = 4;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           addr;
    logic [1:0]            mode;
    logic                  we;
    logic [2:0]            size;
    logic [3:0]            be;
    logic [1:0]            attr;
    logic [31:0]           wdata;
    logic                  last;
    logic                  spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
    logic       dbg;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [31:0]           rdata;
    logic                  err;
    logic                  dbg;
  } x_mem_result_t;

endpackage

// File: rtl/pa_xif_mem.sv
// Constants for the XIF memory responder.
// Exception codes and parameter limits.
package pa_xif_mem;

  localparam logic [5:0] EXC_LOAD_FAULT  = 6'd5;
  localparam logic [5:0] EXC_STORE_FAULT = 6'd7;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 8;
  localparam int GAP_MAX = 15;
  localparam int GAP_W   = 4;

endpackage

// File: rtl/xif_mem_result_pipe.sv
// Fixed-latency result shift pipeline.
// Reset clears every stage so in-flight results vanish.
import pa_xif_mem::*;

module xif_mem_result_pipe #(
  parameter int LATENCY = 2,
  parameter int ID_W    = 4
) (
  input  logic            ck,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [ID_W-1:0] i_id,
  input  logic [31:0]     i_rdata,
  input  logic            i_err,
  output logic            o_valid,
  output logic [ID_W-1:0] o_id,
  output logic [31:0]     o_rdata,
  output logic            o_err
);

  typedef struct packed {
    logic            v;
    logic [ID_W-1:0] id;
    logic [31:0]     rdata;
    logic            err;
  } stg_t;

  stg_t r_stg [LATENCY];

  // Shift one stage per cycle; stage 0 takes the new entry.
  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++)
        r_stg[i] <= '0;
    end else begin
      r_stg[0] <= '{v: i_valid, id: i_id,
                    rdata: i_rdata, err: i_err};
      for (int i = 1; i < LATENCY; i++)
        r_stg[i] <= r_stg[i-1];
    end
  end

  assign o_valid = r_stg[LATENCY-1].v;
  assign o_id    = r_stg[LATENCY-1].id;
  assign o_rdata = r_stg[LATENCY-1].rdata;
  assign o_err   = r_stg[LATENCY-1].err;

endmodule

// File: rtl/xif_mem_responder.sv
// XIF memory responder with word-addressed backing store.
// Define XIF_MEM_ERR_EN for range/alignment faults.
import in_xif::*;
import pa_xif_mem::*;

module xif_mem_responder #(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 2,
  parameter int READY_GAP = 0
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          mem_valid,
  output logic          mem_ready,
  input  x_mem_req_t    mem_req,
  output x_mem_resp_t   mem_resp,
  output logic          mem_result_valid,
  output x_mem_result_t mem_result,
  input  logic [31:0]   dbg_addr,
  output logic [31:0]   dbg_rdata
);

  localparam int AW =
    (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0] r_mem [MEM_WORDS] = '{default: '0};
  logic [GAP_W-1:0] r_gap;

  logic [29:0]     w_word;
  logic [AW-1:0]   w_idx;
  logic [AW-1:0]   w_didx;
  logic            w_acc;
  logic            w_fault;
  logic [31:0]     w_rdata;
  logic            w_pv;
  logic [X_ID_WIDTH-1:0] w_pid;
  logic [31:0]     w_prd;
  logic            w_perr;
  logic            w_unused;

  assign w_word = mem_req.addr[31:2];
  assign w_idx  = AW'(w_word % 30'(MEM_WORDS));
  assign w_didx = AW'(dbg_addr[31:2] % 30'(MEM_WORDS));

  assign mem_ready = !rst && (r_gap == '0);
  assign w_acc     = mem_valid && mem_ready;

`ifdef XIF_MEM_ERR_EN
  assign w_fault =
    ({2'b00, w_word} >= 32'(MEM_WORDS)) ||
    ((mem_req.addr[1:0] != 2'b00) &&
     (mem_req.size == 3'd2));
`else
  assign w_fault = 1'b0;
`endif

  assign w_rdata = (mem_req.we || w_fault) ?
                   '0 : r_mem[w_idx];

  assign dbg_rdata = r_mem[w_didx];

  assign w_unused = ^{dbg_addr[1:0], mem_req.mode,
                      mem_req.spec, mem_req.attr,
                      mem_req.last, mem_req.size};

  // Byte-enabled store on the accepting edge.
  always_ff @(posedge ck) begin
    if (w_acc && mem_req.we && !w_fault) begin
      for (int b = 0; b < 4; b++)
        if (mem_req.be[b])
          r_mem[w_idx][8*b +: 8] <= mem_req.wdata[8*b +: 8];
    end
  end

  // Ready gap: reload on accept, count down to zero.
  always_ff @(posedge ck) begin
    if (rst)
      r_gap <= '0;
    else if (w_acc)
      r_gap <= GAP_W'(READY_GAP);
    else if (r_gap != '0)
      r_gap <= r_gap - 1'b1;
  end

  // Handshake response is combinational on the request.
  always_comb begin
    mem_resp     = '0;
    mem_resp.exc = w_fault;
    if (w_fault)
      mem_resp.exccode = mem_req.we ?
                         EXC_STORE_FAULT : EXC_LOAD_FAULT;
  end

  xif_mem_result_pipe #(
    .LATENCY (LATENCY),
    .ID_W    (X_ID_WIDTH)
  ) u_pipe (
    .ck      (ck),
    .rst     (rst),
    .i_valid (w_acc),
    .i_id    (mem_req.id),
    .i_rdata (w_rdata),
    .i_err   (w_fault),
    .o_valid (w_pv),
    .o_id    (w_pid),
    .o_rdata (w_prd),
    .o_err   (w_perr)
  );

  assign mem_result_valid = w_pv && !rst;

  // Result bundle; debug bit always low.
  always_comb begin
    mem_result       = '0;
    mem_result.id    = w_pid;
    mem_result.rdata = w_prd;
    mem_result.err   = w_perr;
  end

endmodule

// File: doc/xif_mem_responder.md
XIF_MEM_RESPONDER -- requirements
Module: xif_mem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, meaning backing-store depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, range 1..8, meaning cycles from request acceptance to mem_result_valid.
REQ-003 SHALL have parameter READY_GAP, default 0, range 0..15, meaning idle cycles forced on mem_ready after each acceptance.
REQ-004 SHALL have port: ck  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: mem_valid  input  1  coprocessor request valid.
REQ-007 SHALL have port: mem_ready  output  1  request accepted when mem_valid && mem_ready at a rising edge.
REQ-008 SHALL have port: mem_req  input  x_mem_req_t  id, addr, wdata, we, be, size, mode, spec, attr, last.
REQ-009 SHALL have port: mem_resp  output  x_mem_resp_t  exc, exccode, dbg, valid in the same cycle as the handshake.
REQ-010 SHALL have port: mem_result_valid  output  1  one-cycle result strobe, no backpressure.
REQ-011 SHALL have port: mem_result  output  x_mem_result_t  id, rdata, err, dbg.
REQ-012 SHALL have port: dbg_addr  input  32  byte address for bench peek; dbg_rdata  output  32  combinational word at dbg_addr[31:2] mod MEM_WORDS.

Function
REQ-013 SHALL produce exactly one mem_result per accepted request, in acceptance order, for both loads and stores.
REQ-014 SHALL assert mem_result_valid exactly LATENCY rising edges after the accepting edge, carrying that request's id.
REQ-015 SHALL implement latency as a LATENCY-stage shift pipeline of {valid, id, rdata, err}; back-to-back acceptances yield back-to-back results.
REQ-016 SHALL sample load rdata from the array at the accepting edge; for stores, rdata SHALL be 0.
REQ-017 SHALL perform store byte writes at the accepting edge under be[3:0]; a load accepted on a later edge SHALL see the new data.
REQ-018 SHALL index the array by addr[31:2]; addr[1:0] SHALL be ignored for array indexing.
REQ-019 SHALL drive mem_resp.exc = 0, exccode = 0 and dbg = 0 in the non-error case.
REQ-020 SHALL drive mem_result.dbg = 0 at all times.
REQ-021 SHALL run a gap counter: on acceptance, load READY_GAP; while the counter is nonzero, decrement by one per cycle and hold mem_ready = 0.
REQ-022 SHALL drive mem_ready = 1 whenever the gap counter is 0; with READY_GAP = 0, one acceptance per cycle SHALL be sustained.
REQ-023 SHALL ignore mem_req while mem_valid is 0: no store, no pipeline entry.

Reset
REQ-024 SHALL, in any cycle with rst = 1, clear all pipeline valid bits and the gap counter, and drive mem_result_valid = 0 and mem_ready = 0.
REQ-025 SHALL, in the first cycle after rst deasserts, drive mem_ready = 1.
REQ-026 SHALL drop in-flight results on reset mid-operation; they SHALL never emerge.
REQ-027 SHALL NOT clear backing-store contents on rst; contents SHALL be zero at time zero.
REQ-028 SHALL NOT accept a request, and SHALL NOT write the array, on an edge where rst = 1.

Configuration
REQ-029 SHALL, with macro XIF_MEM_ERR_EN defined, flag a request as faulting when addr[31:2] >= MEM_WORDS, or when addr[1:0] != 0 with size = 2.
REQ-030 SHALL, for a faulting request, drive mem_resp.exc = 1 and exccode = 5 (load) or 7 (store), suppress the array write, and return mem_result.err = 1 with rdata = 0.
REQ-031 SHALL, without XIF_MEM_ERR_EN, wrap addresses modulo MEM_WORDS, hold exc = 0 and err = 0, and flag no faults.

Structure
REQ-032 SHALL take x_mem_req_t, x_mem_resp_t and x_mem_result_t from the shared XIF typedef package, in_xif.
REQ-033 SHALL place the exception-code constants (5, 7) and LATENCY/READY_GAP limits in shared package pa_xif_mem.
REQ-034 SHALL implement the latency pipeline as one sub-module, xif_mem_result_pipe.

Verification
REQ-035 Bench SHALL cover: store addr 0x10, wdata 0xDEADBEEF, be 0xF, id 3 -> result id 3, err 0, valid exactly LATENCY = 2 cycles later; dbg_rdata at 0x10 reads 0xDEADBEEF.
REQ-036 Bench SHALL cover: store 0x11223344 to 0x20, then store be = 0x2 with wdata 0x0000AA00, then load 0x20 -> rdata 0x1122AA44.
REQ-037 Bench SHALL cover: four back-to-back loads with ids 0..3 and READY_GAP = 0 -> four consecutive result cycles, ids 0,1,2,3.
REQ-038 Bench SHALL cover: READY_GAP = 3 with mem_valid held high -> mem_ready low for exactly 3 cycles after each acceptance.
REQ-039 Bench SHALL cover: a load accepted, then rst pulsed one cycle before its result is due -> no mem_result_valid, and mem_ready = 1 in the first cycle after reset.
REQ-040 Bench SHALL cover, with XIF_MEM_ERR_EN: load addr = 4*MEM_WORDS -> mem_resp.exc = 1, exccode = 5, result err = 1; without the macro, the same load returns the word at addr 0.
